// File: rtl/mac_pkg.sv
// Shared widths, datapath types and FSM state encoding for the product accumulator.
package mac_pkg;

    localparam int WIDTH       = 8;
    localparam int ACC_WIDTH   = 24;
    localparam int COUNT_WIDTH = 8;

    typedef logic [2*WIDTH-1:0]     product_t;
    typedef logic [ACC_WIDTH-1:0]   acc_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/mac_if.sv
// Product stream in, group result out; slave is the accumulator, master its environment.
interface mac_if
    import mac_pkg::*;
#(
    parameter int Width      = WIDTH,
    parameter int AccWidth   = ACC_WIDTH,
    parameter int CountWidth = COUNT_WIDTH
);

    logic [2*Width-1:0]    product_i;
    logic                  valid_i;
    logic                  last_i;
    logic                  ready_o;
    logic [AccWidth-1:0]   sum_o;
    logic [CountWidth-1:0] count_o;
    logic                  overflow_o;
    logic                  sum_valid_o;
    logic                  sum_ready_i;

    modport slave (
        input  product_i, valid_i, last_i, sum_ready_i,
        output ready_o, sum_o, count_o, overflow_o, sum_valid_o
    );

    modport master (
        output product_i, valid_i, last_i, sum_ready_i,
        input  ready_o, sum_o, count_o, overflow_o, sum_valid_o
    );

endinterface

// File: rtl/mac_sat_adder.sv
// Accumulator adder with carry-out; MAC_SATURATE_EN selects clamping instead of wrapping.
module mac_sat_adder
    import mac_pkg::*;
#(
    parameter int PWidth   = 2*WIDTH,
    parameter int AccWidth = ACC_WIDTH
) (
    input  logic [AccWidth-1:0] acc_i,
    input  logic [PWidth-1:0]   product_i,
    output logic [AccWidth-1:0] sum_o,
    output logic                carry_o
);

    logic [AccWidth:0] raw_s;

    assign raw_s   = {1'b0, acc_i} + (AccWidth+1)'(product_i);
    assign carry_o = raw_s[AccWidth];

`ifdef MAC_SATURATE_EN
    // Once clamped, any non-zero product carries again, so the clamp persists for the group.
    assign sum_o = carry_o ? {AccWidth{1'b1}} : raw_s[AccWidth-1:0];
`else
    assign sum_o = raw_s[AccWidth-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a last_i-delimited group of products and presents sum, beat count and overflow.
// Optional build macro MAC_SATURATE_EN makes the accumulator clamp instead of wrap.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int Width      = WIDTH,
    parameter int AccWidth   = ACC_WIDTH,
    parameter int CountWidth = COUNT_WIDTH
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    mac_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ACCUM = ACCUM;
    localparam logic [1:0] ST_HOLD  = HOLD;

    if (AccWidth < 2*Width) begin : g_width_check
        $error("mac_accumulator: AccWidth must be at least 2*Width");
    end

    logic [1:0]            state_q, state_d;
    logic [AccWidth-1:0]   acc_q, acc_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [AccWidth-1:0]   sum_q, sum_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  sum_valid_q, sum_valid_d;

    logic                  ready_s;
    logic                  beat_s;
    logic [AccWidth-1:0]   add_sum_s;
    logic                  add_carry_s;
    logic [CountWidth-1:0] cnt_inc_s;

    mac_sat_adder #(
        .PWidth   (2*Width),
        .AccWidth (AccWidth)
    ) u_adder (
        .acc_i     (acc_q),
        .product_i (bus.product_i),
        .sum_o     (add_sum_s),
        .carry_o   (add_carry_s)
    );

    assign ready_s   = (state_q != ST_HOLD);
    assign beat_s    = bus.valid_i & ready_s;
    assign cnt_inc_s = (cnt_q == {CountWidth{1'b1}}) ? cnt_q : cnt_q + CountWidth'(1'b1);

    // Next-state, accumulator and result register update.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        sum_valid_d = sum_valid_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (beat_s) begin
                    if (bus.last_i) begin
                        state_d     = ST_HOLD;
                        sum_d       = add_sum_s;
                        count_d     = cnt_inc_s;
                        overflow_d  = ovf_q | add_carry_s;
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                    end else begin
                        state_d = ST_ACCUM;
                        acc_d   = add_sum_s;
                        cnt_d   = cnt_inc_s;
                        ovf_d   = ovf_q | add_carry_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (bus.sum_ready_i) begin
                    state_d     = ST_IDLE;
                    sum_valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                sum_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.ready_o     = ready_s;
    assign bus.sum_o       = sum_q;
    assign bus.count_o     = count_q;
    assign bus.overflow_o  = overflow_q;
    assign bus.sum_valid_o = sum_valid_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed, table-driven bench for mac_accumulator (default or MAC_SATURATE_EN build).
module tb_mac_accumulator;
    import mac_pkg::*;

    typedef struct {
        logic [15:0] product;
        logic        last;
        logic [23:0] exp_sum;
        logic [7:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    vec_t vecs [11];

    mac_if bus ();

    mac_accumulator dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic [15:0] p, input logic l);
        bus.product_i = p;
        bus.last_i    = l;
        bus.valid_i   = 1'b1;
        chk("ready_before_beat", {31'd0, bus.ready_o}, 32'd1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic chk_result(input string name, input logic [23:0] s, input logic [7:0] c,
                              input logic o);
        chk({name, "_valid"}, {31'd0, bus.sum_valid_o}, 32'd1);
        chk({name, "_sum"},   {8'd0, bus.sum_o},        {8'd0, s});
        chk({name, "_count"}, {24'd0, bus.count_o},     {24'd0, c});
        chk({name, "_ovf"},   {31'd0, bus.overflow_o},  {31'd0, o});
    endtask

    initial begin
        logic [23:0] ovf_exp;
        tests = 0;
        fails = 0;
        vecs[0]  = '{16'd14,    1'b0, 24'd0,      8'd0, 1'b0};
        vecs[1]  = '{16'd20678, 1'b0, 24'd0,      8'd0, 1'b0};
        vecs[2]  = '{16'd9471,  1'b0, 24'd0,      8'd0, 1'b0};
        vecs[3]  = '{16'd0,     1'b0, 24'd0,      8'd0, 1'b0};
        vecs[4]  = '{16'd65025, 1'b1, 24'd95188,  8'd5, 1'b0};
        vecs[5]  = '{16'd14,    1'b1, 24'd14,     8'd1, 1'b0};
        vecs[6]  = '{16'd65025, 1'b0, 24'd0,      8'd0, 1'b0};
        vecs[7]  = '{16'd65025, 1'b0, 24'd0,      8'd0, 1'b0};
        vecs[8]  = '{16'd65025, 1'b0, 24'd0,      8'd0, 1'b0};
        vecs[9]  = '{16'd14,    1'b1, 24'd195089, 8'd4, 1'b0};
        vecs[10] = '{16'd65535, 1'b1, 24'd65535,  8'd1, 1'b0};

        rst_n           = 1'b0;
        bus.valid_i     = 1'b0;
        bus.last_i      = 1'b0;
        bus.product_i   = 16'd0;
        bus.sum_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum",       {8'd0, bus.sum_o},          32'd0);
        chk("reset_count",     {24'd0, bus.count_o},       32'd0);
        chk("reset_ovf",       {31'd0, bus.overflow_o},    32'd0);
        chk("reset_sum_valid", {31'd0, bus.sum_valid_o},   32'd0);
        chk("reset_ready",     {31'd0, bus.ready_o},       32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: groups with sum_ready_i held high.
        for (int i = 0; i < 11; i++) begin
            beat(vecs[i].product, vecs[i].last);
            if (vecs[i].last) begin
                chk_result("table", vecs[i].exp_sum, vecs[i].exp_cnt, vecs[i].exp_ovf);
                chk("table_hold_ready", {31'd0, bus.ready_o}, 32'd0);
                @(posedge clk); #1;
                chk("table_handoff_valid", {31'd0, bus.sum_valid_o}, 32'd0);
                chk("table_handoff_ready", {31'd0, bus.ready_o},     32'd1);
                chk("table_sum_kept",      {8'd0, bus.sum_o},        {8'd0, vecs[i].exp_sum});
            end else begin
                chk("table_partial_valid", {31'd0, bus.sum_valid_o}, 32'd0);
            end
        end

        // Backpressure: result held for 3 cycles with a pending beat on the input.
        beat(16'd7, 1'b1);
        bus.sum_ready_i = 1'b0;
        bus.product_i   = 16'd5;
        bus.last_i      = 1'b1;
        bus.valid_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_ready_low", {31'd0, bus.ready_o}, 32'd0);
            chk_result("bp_hold", 24'd7, 8'd1, 1'b0);
        end
        bus.sum_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, bus.sum_valid_o}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.ready_o},     32'd1);
        chk("bp_release_sum",   {8'd0, bus.sum_o},        32'd7);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        chk_result("bp_next", 24'd5, 8'd1, 1'b0);
        @(posedge clk); #1;

        // Overflow: 259 beats of 65025 with a saturating beat counter.
`ifdef MAC_SATURATE_EN
        ovf_exp = 24'd16777215;
`else
        ovf_exp = 24'd64259;
`endif
        for (int i = 0; i < 258; i++) beat(16'd65025, 1'b0);
        beat(16'd65025, 1'b1);
        chk_result("overflow", ovf_exp, 8'd255, 1'b1);
        @(posedge clk); #1;

        // Reset mid-group discards the partial sum.
        for (int i = 0; i < 3; i++) beat(16'd65025, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_sum",   {8'd0, bus.sum_o},        32'd0);
        chk("midrst_ready", {31'd0, bus.ready_o},     32'd1);
        chk("midrst_state", {30'd0, dut.state_q},     {30'd0, 2'(IDLE)});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(16'd14, 1'b1);
        chk_result("midrst", 24'd14, 8'd1, 1'b0);
        @(posedge clk); #1;

        // Gaps: valid_i low between beats keeps the partial sum in ACCUM.
        beat(16'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("gap1_state", {30'd0, dut.state_q}, {30'd0, 2'(ACCUM)});
        end
        beat(16'd3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("gap2_state", {30'd0, dut.state_q}, {30'd0, 2'(ACCUM)});
        end
        beat(16'd5, 1'b1);
        chk_result("gaps", 24'd10, 8'd3, 1'b0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the multiplier product stream.
- Accumulates a group of 2*Width-bit products, delimited by last_i, into one AccWidth-bit sum.
- Emits the sum, a beat count and an overflow flag on a valid/ready output.
- Turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- Width, 8, multiplicand width; product width is 2*Width.
- AccWidth, 24, accumulator and sum width; elaboration error if AccWidth < 2*Width.
- CountWidth, 8, width of the beat counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- product_i  in  2*Width  product from the multiplier.
- valid_i  in  1  product_i/last_i valid.
- last_i  in  1  final product of the current group.
- ready_o  out  1  block accepts a beat this cycle.
- sum_o  out  AccWidth  accumulated group sum.
- count_o  out  CountWidth  number of beats in the group.
- overflow_o  out  1  group exceeded AccWidth range.
- sum_valid_o  out  1  sum_o/count_o/overflow_o valid.
- sum_ready_i  in  1  downstream accepts the result.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; acc, beat counter and overflow accumulator = 0.
  - sum_o=0, count_o=0, overflow_o=0, sum_valid_o=0.
  - ready_o=1 (from state).
- ready_o = (state != HOLD), purely combinational from state. No combinational path from valid_i or sum_ready_i to ready_o.
- Beat accepted when valid_i && ready_o.
- On each accepted beat:
  - acc_next = acc + zero-extended product_i.
  - cnt_next = cnt + 1, saturating at 2^CountWidth-1.
  - ovf_next = ovf | carry-out of the add.
- States:
  - IDLE: no partial sum. Beat with !last_i -> ACCUM. Beat with last_i -> HOLD.
  - ACCUM: partial sum held. Beat with !last_i stays ACCUM. Beat with last_i -> HOLD.
  - HOLD: result presented, ready_o=0. sum_ready_i=1 -> sum_valid_o=0 and go to IDLE.
- Entering HOLD (the cycle the last beat is accepted):
  - Register sum_o=acc_next, count_o=cnt_next, overflow_o=ovf_next; set sum_valid_o=1.
  - Clear acc, cnt and ovf.
- Latency: last beat accepted at edge N; sum_valid_o high after edge N. Single-beat group: sum_o = product_i, count_o = 1.
- Output stability: sum_o, count_o and overflow_o hold stable while sum_valid_o=1 && !sum_ready_i.
- Output between results: sum_o, count_o and overflow_o keep their last values after handoff; only sum_valid_o drops.
- Throughput:
  - One product per cycle inside a group.
  - One bubble cycle (HOLD) per group, minimum, while ready_o is low.
- valid_i=0 in ACCUM: hold state and the partial sum indefinitely.
- Reset mid-group or in HOLD: discard the partial sum and any pending result; return to the reset values.

Optional Feature:
- MAC_SATURATE_EN defined: on carry-out, acc clamps to 2^AccWidth-1 and stays clamped for the rest of the group; overflow_o=1.
- Not defined: the add wraps modulo 2^AccWidth; overflow_o still reports any carry-out in the group.
- Port list is identical in both builds.

Decomposition:
- Package mac_pkg holds:
  - Width, AccWidth and CountWidth defaults.
  - product_t, acc_t, count_t typedefs.
  - state_e enum {IDLE, ACCUM, HOLD}.
- Sub-module mac_sat_adder, combinational:
  - Inputs: acc_t, product_t.
  - Outputs: acc_t result and a carry flag.
  - Contains the MAC_SATURATE_EN conditional.
- FSM, counter and output registers live in mac_accumulator.

Test Plan:
- Stream products 14, 20678, 9471, 0, 65025, last on the 5th, sum_ready_i=1 -> sum_o=95188, count_o=5, overflow_o=0; sum_valid_o high one cycle after the 5th beat.
- Single beat product 14 with last_i -> sum_o=14, count_o=1; ready_o low for exactly one cycle.
- Backpressure: hold sum_ready_i=0 for 3 cycles after a result, valid_i held high -> ready_o=0, sum_o stable, no beat consumed; the beat is accepted in the cycle after sum_ready_i rises.
- Overflow: 259 beats of 65025, last on the 259th.
  - With MAC_SATURATE_EN: sum_o=16777215, overflow_o=1, count_o=255.
  - Without: sum_o=64259, overflow_o=1, count_o=255.
- Reset mid-group: 3 beats of 65025 without last, assert rst_ni low for 1 cycle, then one beat of 14 with last -> sum_o=14, count_o=1, overflow_o=0.
- Gaps: beats 2, 3, last 5, with 2-cycle valid_i=0 gaps between them -> sum_o=10, count_o=3; state stays ACCUM through the gaps.
